// File: rtl/msu_audio_server_pkg.sv
// msu_pkg: shared FSM state type and sector geometry for the MSU audio server.
package msu_pkg;
  typedef enum logic [2:0] {IDLE, SEEK, FETCH, WAIT, WRITE, DONE} state_t;
  localparam int SECTOR_BYTES = 1024;
  localparam int SECTOR_WORDS = 512;
endpackage

// File: rtl/msu_audio_server_if.sv
// msu_audio_if / msu_mem_if: audio sector request bus and backing-memory read bus.
interface msu_audio_if;
  logic audio_req;
  logic audio_seek;
  logic [21:0] audio_sector;
  logic audio_ack;
  logic audio_download;
  logic audio_data_wr;
  logic [15:0] audio_data;
  modport master(output audio_req, audio_seek, audio_sector, input audio_ack, audio_download, audio_data_wr, audio_data);
  modport slave(input audio_req, audio_seek, audio_sector, output audio_ack, audio_download, audio_data_wr, audio_data);
endinterface

interface msu_mem_if;
  logic [31:0] mem_addr;
  logic mem_rd;
  logic mem_ready;
  logic [15:0] mem_dout;
  modport master(output mem_addr, mem_rd, input mem_ready, mem_dout);
  modport slave(input mem_addr, mem_rd, output mem_ready, mem_dout);
endinterface

// File: rtl/msu_audio_server.sv
// msu_audio_server: streams one track sector word-by-word from memory, zero-padding past end of file.
// Define MSU_AUDIO_SEEK_DELAY_EN to hold audio_seek requests in SEEK for SEEK_CYCLES before delivery.
module msu_audio_server import msu_pkg::*; #(
  parameter int SECTOR_WORDS = msu_pkg::SECTOR_WORDS,
  parameter int SEEK_CYCLES = 64
) (
  input logic clk,
  input logic reset,
  input logic track_processing,
  input logic [31:0] track_base,
  input logic [31:0] track_size,
  msu_audio_if.slave au,
  msu_mem_if.master mem
);
  localparam int WW = $clog2(SECTOR_WORDS);
  state_t state;
  logic [21:0] sector;
  logic [WW-1:0] w;
  logic [31:0] off;
  always_comb off = 32'(sector) * 32'(SECTOR_BYTES) + 32'({w, 1'b0});
`ifdef MSU_AUDIO_SEEK_DELAY_EN
  localparam int CW = $clog2(SEEK_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  localparam int unused_seek_cycles = SEEK_CYCLES;
`endif
  // track_processing aborts exactly like reset; any in-flight mem_ready is simply never consumed
  always_ff @(posedge clk) begin
    if (reset || track_processing) begin
      state <= IDLE;
      sector <= '0;
      w <= '0;
      au.audio_ack <= 1'b0;
      au.audio_download <= 1'b0;
      au.audio_data_wr <= 1'b0;
      au.audio_data <= '0;
      mem.mem_rd <= 1'b0;
      mem.mem_addr <= '0;
`ifdef MSU_AUDIO_SEEK_DELAY_EN
      cnt <= '0;
`endif
    end else begin
      au.audio_data_wr <= 1'b0;
      mem.mem_rd <= 1'b0;
      case (state)
        IDLE: if (au.audio_req || au.audio_seek) begin
          sector <= au.audio_sector;
          w <= '0;
`ifdef MSU_AUDIO_SEEK_DELAY_EN
          cnt <= '0;
          state <= au.audio_seek ? SEEK : FETCH;
          au.audio_ack <= !au.audio_seek;
          au.audio_download <= !au.audio_seek;
`else
          state <= FETCH;
          au.audio_ack <= 1'b1;
          au.audio_download <= 1'b1;
`endif
        end
`ifdef MSU_AUDIO_SEEK_DELAY_EN
        SEEK: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SEEK_CYCLES - 1)) begin
            state <= FETCH;
            au.audio_ack <= 1'b1;
            au.audio_download <= 1'b1;
          end
        end
`endif
        FETCH: if (off < track_size) begin
          mem.mem_rd <= 1'b1;
          mem.mem_addr <= track_base + off;
          state <= WAIT;
        end else begin
          au.audio_data <= '0;
          state <= WRITE;
        end
        WAIT: if (mem.mem_ready) begin
          au.audio_data <= mem.mem_dout;
          state <= WRITE;
        end
        WRITE: begin
          au.audio_data_wr <= 1'b1;
          w <= w + 1'b1;
          state <= (w == WW'(SECTOR_WORDS - 1)) ? DONE : FETCH;
        end
        DONE: begin
          au.audio_ack <= 1'b0;
          au.audio_download <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msu_audio_server.sv
// tb_msu_audio_server: directed/randomized bench with a memory responder and a per-sector reference model.
module tb_msu_audio_server;
  logic clk = 1'b0;
  logic reset, track_processing;
  logic [31:0] track_base, track_size;
  msu_audio_if au();
  msu_mem_if mem();
  int checks = 0, errors = 0;
  int lat = 2;
  logic [15:0] key;
  logic [15:0] got[$];
  logic [31:0] addrs[$];
  int gap_err = 0, pair_err = 0;
  logic prev_wr = 1'b0;
  logic [31:0] rd_a;

  always #5 clk = ~clk;

  msu_audio_server #(.SECTOR_WORDS(512), .SEEK_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .track_processing(track_processing),
    .track_base(track_base), .track_size(track_size),
    .au(au.slave), .mem(mem.master)
  );

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ key;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic wait_ack(input logic lvl, input int limit, output int n);
    n = 0;
    while (au.audio_ack !== lvl && n < limit) begin cyc(1); n++; end
  endtask

  task automatic do_sector(input string tag, input logic [21:0] s, input logic r, input logic sk, output int d);
    int n;
    got.delete();
    addrs.delete();
    au.audio_sector = s;
    au.audio_req = r;
    au.audio_seek = sk;
    wait_ack(1'b1, 200, d);
    au.audio_req = 1'b0;
    au.audio_seek = 1'b0;
    check({tag, " ack rise"}, au.audio_ack, 1);
    check({tag, " download rise"}, au.audio_download, 1);
    wait_ack(1'b0, 5000, n);
    check({tag, " ack fall"}, au.audio_ack, 0);
  endtask

  // Expected sector: word i lives at byte offset s*1024+2i; past track_size it reads as zero with no fetch
  task automatic expect_sector(input string tag, input logic [21:0] s);
    int bad_w, bad_a, nrd;
    logic [31:0] o;
    logic [15:0] e;
    bad_w = 0; bad_a = 0; nrd = 0;
    for (int i = 0; i < 512; i++) begin
      o = 32'(s) * 32'd1024 + 32'(2 * i);
      if (o < track_size) begin
        e = mem_word(track_base + o);
        if (nrd >= addrs.size() || addrs[nrd] !== track_base + o) bad_a++;
        nrd++;
      end else e = 16'h0000;
      if (i >= got.size() || got[i] !== e) bad_w++;
    end
    check({tag, " words"}, got.size(), 512);
    check({tag, " data"}, bad_w, 0);
    check({tag, " reads"}, addrs.size(), nrd);
    check({tag, " addr"}, bad_a, 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (au.audio_data_wr === 1'b1) begin
      got.push_back(au.audio_data);
      if (prev_wr) gap_err++;
    end
    prev_wr = (au.audio_data_wr === 1'b1);
    if (mem.mem_rd === 1'b1) addrs.push_back(mem.mem_addr);
    if (au.audio_ack !== au.audio_download) pair_err++;
  end

  initial begin
    mem.mem_ready = 1'b0;
    mem.mem_dout = '0;
    forever begin
      @(posedge clk); #2;
      if (mem.mem_rd === 1'b1) begin
        rd_a = mem.mem_addr;
        repeat (lat) begin @(posedge clk); #2; end
        mem.mem_ready = 1'b1;
        mem.mem_dout = mem_word(rd_a);
        @(posedge clk); #2;
        mem.mem_ready = 1'b0;
        mem.mem_dout = 16'($urandom);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d, d2, n;
    logic [21:0] s;
    reset = 1'b1;
    track_processing = 1'b0;
    track_base = '0;
    track_size = '0;
    au.audio_req = 1'b0;
    au.audio_seek = 1'b0;
    au.audio_sector = '0;
    key = 16'($urandom);
    cyc(3);
    check("reset ack", au.audio_ack, 0);
    check("reset download", au.audio_download, 0);
    check("reset data_wr", au.audio_data_wr, 0);
    check("reset data", au.audio_data, 0);
    check("reset mem_rd", mem.mem_rd, 0);
    check("reset mem_addr", mem.mem_addr, 0);
    reset = 1'b0;
    cyc(2);
    track_base = $urandom & 32'hFFFF_FFFE;
    track_size = 4096;
    lat = 2;
    do_sector("basic", 0, 1'b1, 1'b0, d);
    check("basic ack delay", d, 1);
    expect_sector("basic", 0);
    check("basic first addr", addrs.size() > 0 ? addrs[0] : 32'hx, track_base);
    track_size = 3 * 1024 + 100;
    do_sector("tail", 3, 1'b1, 1'b0, d);
    expect_sector("tail", 3);
    check("tail read count", addrs.size(), 50);
    for (int k = 0; k < 3; k++) begin
      s = 22'($urandom_range(0, 15));
      track_base = (k == 2) ? 32'hFFFF_FE00 : ($urandom & 32'hFFFF_FFFE);
      track_size = $urandom_range(0, 20 * 1024);
      lat = $urandom_range(0, 3);
      key = 16'($urandom);
      do_sector($sformatf("rand%0d", k), s, 1'b1, 1'b0, d);
      expect_sector($sformatf("rand%0d", k), s);
    end
    track_base = $urandom & 32'hFFFF_FFFE;
    track_size = 16 * 1024;
    lat = 1;
    got.delete();
    addrs.delete();
    au.audio_sector = 5;
    au.audio_req = 1'b1;
    wait_ack(1'b1, 200, d);
    au.audio_req = 1'b0;
    n = 0;
    while (got.size() < 100 && n < 5000) begin cyc(1); n++; end
    check("abort reached 100", got.size(), 100);
    track_processing = 1'b1;
    cyc(1);
    check("abort ack", au.audio_ack, 0);
    check("abort download", au.audio_download, 0);
    check("abort data_wr", au.audio_data_wr, 0);
    check("abort mem_rd", mem.mem_rd, 0);
    track_processing = 1'b0;
    cyc(20);
    check("abort no strobes", got.size(), 100);
    do_sector("after abort", 5, 1'b1, 1'b0, d);
    expect_sector("after abort", 5);
    track_size = 8 * 1024;
    do_sector("b2b first", 1, 1'b1, 1'b0, d);
    expect_sector("b2b first", 1);
    do_sector("b2b second", 2, 1'b1, 1'b0, d2);
    check("b2b download gap", d2 >= 1, 1);
    expect_sector("b2b second", 2);
    got.delete();
    au.audio_sector = 4;
    au.audio_req = 1'b1;
    wait_ack(1'b1, 200, d);
    au.audio_req = 1'b0;
    n = 0;
    while (got.size() < 300 && n < 5000) begin cyc(1); n++; end
    check("reset mid reached 300", got.size(), 300);
    reset = 1'b1;
    cyc(1);
    check("mid reset ack", au.audio_ack, 0);
    check("mid reset download", au.audio_download, 0);
    check("mid reset data_wr", au.audio_data_wr, 0);
    check("mid reset data", au.audio_data, 0);
    check("mid reset mem_rd", mem.mem_rd, 0);
    check("mid reset mem_addr", mem.mem_addr, 0);
    reset = 1'b0;
    cyc(20);
    check("mid reset no strobes", got.size(), 300);
    do_sector("seek", 7, 1'b0, 1'b1, d);
`ifdef MSU_AUDIO_SEEK_DELAY_EN
    check("seek ack delay", d, 65);
`else
    check("seek ack delay", d, 1);
`endif
    expect_sector("seek", 7);
    do_sector("req+seek", 2, 1'b1, 1'b1, d);
    cyc(10);
    expect_sector("req+seek", 2);
    check("strobe gap", gap_err, 0);
    check("ack/download pairing", pair_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
